branch_resolve_unit: RTL

Parametrised branch resolution stage for the EXU. It decodes the 3-bit Branch type together with the ALU Zero/Less flags into PC-select controls. Results are registered behind a one-deep valid/ready stage. It also keeps a PC-indexed table of 2-bit saturating counters, used both for fetch-side prediction and to detect mispredicts.

---
 rtl/branch_resolve_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: decodes branch type plus ALU Zero/Less flags into
// PC-select controls, registers them behind a one-deep valid/ready stage,
// and maintains a PC-indexed table of 2-bit saturating counters used for
// fetch-side prediction and for mispredict detection.
// Optional build macro: BRU_PERF_CNT_EN adds perf_branches/perf_mispredicts.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_branch,
    input  logic            in_zero,
    input  logic            in_less,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_pca_src,
    output logic            out_pcb_src,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_pc,
    input  logic            flush,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic                  out_valid_reg;
    logic                  out_pca_src_reg;
    logic                  out_pcb_src_reg;
    logic                  out_taken_reg;
    logic                  out_mispredict_reg;
    logic [XLEN-1:0]       out_pc_reg;

    logic [BHT_ENTRIES-1:0][1:0] bht_reg;
    logic [BHT_ENTRIES-1:0][1:0] bht_next;

    logic                  accept;
    logic                  taken_c;
    logic                  mispredict_c;
    logic                  bht_wr;
    logic [IDX_W-1:0]      upd_idx;
    logic [IDX_W-1:0]      pred_idx;

    // Only the word-index bits of pred_pc select a counter; the rest alias.
    logic                  unused_pred_bits;
    assign unused_pred_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign upd_idx  = in_pc[IDX_W+1:2];
    assign pred_idx = pred_pc[IDX_W+1:2];
    // Only conditional branches train the table; flush already blocks accept.
    assign bht_wr   = accept && in_branch[2];

    // Read returns the current (pre-update) counter; no write bypass.
    assign pred_taken = bht_reg[pred_idx][1];

    // Branch-type decode into taken and mispredict.
    always_comb begin
        taken_c      = 1'b0;
        mispredict_c = 1'b0;
        case (in_branch)
            3'b000: begin taken_c = 1'b0;     mispredict_c = in_pred_taken;  end
            3'b001: begin taken_c = 1'b1;     mispredict_c = !in_pred_taken; end
            3'b010,
            3'b011: begin taken_c = 1'b1;     mispredict_c = 1'b1;           end
            3'b100: begin taken_c = in_zero;  mispredict_c = (in_zero  != in_pred_taken); end
            3'b101: begin taken_c = !in_zero; mispredict_c = (!in_zero != in_pred_taken); end
            3'b110: begin taken_c = in_less;  mispredict_c = (in_less  != in_pred_taken); end
            default: begin taken_c = !in_less; mispredict_c = (!in_less != in_pred_taken); end
        endcase
    end

    // Per-entry saturating counter update, selected by the resolving PC.
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        logic hit;
        assign hit = bht_wr && (upd_idx == IDX_W'(gi));
        assign bht_next[gi] = !hit ? bht_reg[gi] :
                              taken_c ? ((bht_reg[gi] == 2'b11) ? 2'b11 : bht_reg[gi] + 2'b01) :
                                        ((bht_reg[gi] == 2'b00) ? 2'b00 : bht_reg[gi] - 2'b01);
    end

    // Counter table register; reset to weakly not-taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_reg <= {BHT_ENTRIES{2'b01}};
        end else begin
            bht_reg <= bht_next;
        end
    end

    // Output stage: flush kills, accept loads, otherwise drain when consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg      <= 1'b0;
            out_pca_src_reg    <= 1'b0;
            out_pcb_src_reg    <= 1'b0;
            out_taken_reg      <= 1'b0;
            out_mispredict_reg <= 1'b0;
            out_pc_reg         <= '0;
        end else if (flush) begin
            out_valid_reg      <= 1'b0;
        end else if (accept) begin
            out_valid_reg      <= 1'b1;
            out_pca_src_reg    <= taken_c;
            out_pcb_src_reg    <= (in_branch[2:1] == 2'b01);
            out_taken_reg      <= taken_c;
            out_mispredict_reg <= mispredict_c;
            out_pc_reg         <= in_pc;
        end else if (out_ready) begin
            out_valid_reg      <= 1'b0;
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_pca_src    = out_pca_src_reg;
    assign out_pcb_src    = out_pcb_src_reg;
    assign out_taken      = out_taken_reg;
    assign out_mispredict = out_mispredict_reg;
    assign out_pc         = out_pc_reg;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_reg;
    logic [31:0] perf_mispredicts_reg;

    // Event counters on accepted requests; free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches_reg    <= '0;
            perf_mispredicts_reg <= '0;
        end else if (accept) begin
            if (in_branch != 3'b000) perf_branches_reg    <= perf_branches_reg + 32'd1;
            if (mispredict_c)        perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
        end
    end

    assign perf_branches    = perf_branches_reg;
    assign perf_mispredicts = perf_mispredicts_reg;
`endif

endmodule
